// File: rtl/spi_slave_xfer_if.sv
// Word-level stream handshake between the SPI slave and its local consumer/producer.
// The slave modport faces the SPI engine; the master modport faces the system logic.
interface spi_slave_xfer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid
    );

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_slave_xfer.sv
// SPI slave oversampled by clk: synchronized pins, all four SPI modes, one-word TX
// holding buffer and RX output register with overrun/underrun/frame-error pulses.
module spi_slave_xfer #(
    parameter int                DATA_W    = 8,
    parameter bit                CPOL      = 1'b0,
    parameter bit                CPHA      = 1'b0,
    parameter bit                MSB_FIRST = 1'b1,
    parameter logic [DATA_W-1:0] FILL      = {DATA_W{1'b1}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            SCK,
    input  logic            SS,
    input  logic            MOSI,
    output logic            MISO,
    output logic            miso_oe,
    spi_slave_xfer_if.slave bus,
    output logic            rx_overrun,
    output logic            tx_underrun,
    output logic            frame_err,
    output logic            busy
);
    localparam int                CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_W - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t            state, state_nxt;
    logic [1:0]        sck_sync, ss_sync, mosi_sync;
    logic              sck_prev, ss_prev;
    logic [1:0]        warm_cnt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] tx_shift, rx_shift, holding, rx_data_q;
    logic              holding_full, tx_ready_q, rx_valid_q, miso_q;

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction

    // NOTE: every clocked block uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sck_sync  <= {2{CPOL}};
            ss_sync   <= 2'b11;
            mosi_sync <= 2'b00;
            sck_prev  <= CPOL;
            ss_prev   <= 1'b1;
            warm_cnt  <= 2'd0;
        end else begin
            sck_sync  <= {sck_sync[0], SCK};
            ss_sync   <= {ss_sync[0], SS};
            mosi_sync <= {mosi_sync[0], MOSI};
            sck_prev  <= sck_sync[1];
            ss_prev   <= ss_sync[1];
            if (warm_cnt != 2'd3) warm_cnt <= warm_cnt + 2'd1;
        end
    end

    // Edges are only trusted once the pipeline holds real pin samples, so an SS
    // still low at reset release is not mistaken for a fresh falling edge.
    logic warm, sck_rise, sck_fall, leading, trailing, sample_edge, shift_edge;
    logic ss_fall, ss_rise, mosi_s;
    assign warm        = (warm_cnt == 2'd3);
    assign mosi_s      = mosi_sync[1];
    assign sck_rise    = warm &  sck_sync[1] & ~sck_prev;
    assign sck_fall    = warm & ~sck_sync[1] &  sck_prev;
    assign ss_fall     = warm & ~ss_sync[1]  &  ss_prev;
    assign ss_rise     = warm &  ss_sync[1]  & ~ss_prev;
    assign leading     = CPOL ? sck_fall : sck_rise;
    assign trailing    = CPOL ? sck_rise : sck_fall;
    assign sample_edge = CPHA ? trailing : leading;
    assign shift_edge  = CPHA ? leading  : trailing;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // NOTE: combinational blocks assign a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ss_fall) state_nxt = ACTIVE;
            ACTIVE:  if (ss_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state == ACTIVE);
        miso_oe = busy;
        MISO    = busy & miso_q;
    end

    logic starting, in_word, sample, word_end, do_shift, load, tx_write, hold_full_nxt;
    logic [DATA_W-1:0] rx_word, load_word;
    assign starting  = (state == IDLE) & ss_fall;
    assign in_word   = (state == ACTIVE) & ~ss_rise;
    assign sample    = in_word & sample_edge;
    assign word_end  = sample & (bit_cnt == LAST);
    // In CPHA=0 the first bit is already on MISO after the load, so the shift
    // edge that follows a word boundary must not advance the register.
    assign do_shift  = in_word & shift_edge & (CPHA | (bit_cnt != '0));
    assign load      = starting | word_end;
    assign rx_word   = MSB_FIRST ? {rx_shift[DATA_W-2:0], mosi_s} : {mosi_s, rx_shift[DATA_W-1:1]};
    assign load_word = holding_full ? holding : FILL;
    assign tx_write  = bus.tx_valid & tx_ready_q;
    assign hold_full_nxt = (holding_full & ~load) | tx_write;

    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_cnt      <= '0;
            tx_shift     <= '0;
            rx_shift     <= '0;
            holding      <= '0;
            holding_full <= 1'b0;
            tx_ready_q   <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            miso_q       <= 1'b0;
            rx_overrun   <= 1'b0;
            tx_underrun  <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            rx_overrun   <= 1'b0;
            tx_underrun  <= 1'b0;
            frame_err    <= 1'b0;
            holding_full <= hold_full_nxt;
            tx_ready_q   <= ~hold_full_nxt;
            if (tx_write) holding <= bus.tx_data;

            if (load) begin
                if (!holding_full) tx_underrun <= 1'b1;
                if (CPHA) begin
                    tx_shift <= load_word;
                end else begin
                    miso_q   <= first_bit(load_word);
                    tx_shift <= shift_out(load_word);
                end
            end else if (do_shift) begin
                miso_q   <= first_bit(tx_shift);
                tx_shift <= shift_out(tx_shift);
            end

            if (starting) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
            end else if ((state == ACTIVE) && ss_rise) begin
                frame_err <= (bit_cnt != '0);
                bit_cnt   <= '0;
                rx_shift  <= '0;
                miso_q    <= 1'b0;
            end else if (sample) begin
                rx_shift <= rx_word;
                bit_cnt  <= word_end ? '0 : bit_cnt + 1'b1;
            end

            if (word_end) begin
                if (!rx_valid_q || bus.rx_ready) begin
                    rx_data_q  <= rx_word;
                    rx_valid_q <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_valid_q && bus.rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign bus.tx_ready = tx_ready_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
endmodule

// File: tb/tb_spi_slave_xfer.sv
// Directed bench: five slaves (modes 0..3 MSB-first, mode 0 LSB-first) driven by a
// behavioural SPI master; vector table plus hand-written multi-cycle sequences.
module tb_spi_slave_xfer;
    localparam int N = 5;
    localparam int H = 80;  // SCK half period: 8 clk cycles

    logic       clk = 1'b0;
    logic       rst;
    logic       mosi;
    logic       sck        [N];
    logic       ss         [N];
    logic       miso       [N];
    logic       miso_oe    [N];
    logic [7:0] tx_data    [N];
    logic       tx_valid   [N];
    logic       tx_ready   [N];
    logic [7:0] rx_data    [N];
    logic       rx_valid   [N];
    logic       rx_ready   [N];
    logic       rx_overrun [N];
    logic       tx_underrun[N];
    logic       frame_err  [N];
    logic       busy       [N];

    int und_cnt [N];
    int ovr_cnt [N];
    int ferr_cnt[N];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        spi_slave_xfer_if #(.DATA_W(8)) bus_if ();
        assign bus_if.tx_data  = tx_data[g];
        assign bus_if.tx_valid = tx_valid[g];
        assign bus_if.rx_ready = rx_ready[g];
        assign tx_ready[g]     = bus_if.tx_ready;
        assign rx_data[g]      = bus_if.rx_data;
        assign rx_valid[g]     = bus_if.rx_valid;

        spi_slave_xfer #(
            .DATA_W(8), .CPOL(g == 2 || g == 3), .CPHA(g == 1 || g == 3),
            .MSB_FIRST(g != 4), .FILL(8'hFF)
        ) dut (
            .clk(clk), .rst(rst), .SCK(sck[g]), .SS(ss[g]), .MOSI(mosi),
            .MISO(miso[g]), .miso_oe(miso_oe[g]), .bus(bus_if),
            .rx_overrun(rx_overrun[g]), .tx_underrun(tx_underrun[g]),
            .frame_err(frame_err[g]), .busy(busy[g])
        );
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            und_cnt[i] = 0; ovr_cnt[i] = 0; ferr_cnt[i] = 0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (tx_underrun[i] === 1'b1) und_cnt[i]  <= und_cnt[i] + 1;
            if (rx_overrun[i]  === 1'b1) ovr_cnt[i]  <= ovr_cnt[i] + 1;
            if (frame_err[i]   === 1'b1) ferr_cnt[i] <= ferr_cnt[i] + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic cpol_of(input int d); return (d == 2 || d == 3); endfunction
    function automatic logic cpha_of(input int d); return (d == 1 || d == 3); endfunction
    function automatic logic msb_of (input int d); return (d != 4);           endfunction

    task automatic push(input int d, input logic [7:0] v);
        int n = 0;
        @(negedge clk);
        while (tx_ready[d] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("push_ready_d%0d", d), 32'(tx_ready[d]), 32'd1);
        if (tx_ready[d] === 1'b1) begin
            tx_data[d]  = v;
            tx_valid[d] = 1'b1;
            @(negedge clk);
            tx_valid[d] = 1'b0;
        end
    endtask

    task automatic pop(input int d);
        int n = 0;
        while (rx_valid[d] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        rx_ready[d] = 1'b1;
        @(negedge clk);
        rx_ready[d] = 1'b0;
        check($sformatf("pop_clears_valid_d%0d", d), 32'(rx_valid[d]), 32'd0);
    endtask

    task automatic ss_low(input int d);
        ss[d] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic ss_high(input int d);
        #(H);
        ss[d] = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Behavioural master; MISO is collected in the same bit order the slave uses.
    task automatic xfer(input int d, input logic [7:0] w, input int nbits,
                        output logic [7:0] mw, output logic first);
        logic cpol, cpha, msb, b;
        int   bi;
        cpol = cpol_of(d); cpha = cpha_of(d); msb = msb_of(d);
        mw = 8'h00; first = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            bi = msb ? 7 - i : i;
            if (!cpha) begin
                mosi = w[bi];
                #(H);
                b = miso[d];
                sck[d] = ~cpol;
                #(H);
                sck[d] = cpol;
            end else begin
                #(H);
                sck[d] = ~cpol;
                mosi = w[bi];
                #(H);
                b = miso[d];
                sck[d] = cpol;
            end
            if (i == 0) first = b;
            mw = msb ? {mw[6:0], b} : {b, mw[7:1]};
        end
    endtask

    typedef struct {
        int         dut;
        logic [7:0] tx;
        logic [7:0] mosi_w;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
        logic       exp_first;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [7:0] mw, mw2;
        logic       fb;
        int         d, u0, o0, f0;

        vecs[0] = '{0, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 1'b1};
        vecs[1] = '{1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 1'b1};
        vecs[2] = '{2, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 1'b1};
        vecs[3] = '{3, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 1'b1};
        vecs[4] = '{4, 8'h01, 8'h3C, 8'h01, 8'h3C, 1'b1};
        vecs[5] = '{0, 8'h5A, 8'hC3, 8'h5A, 8'hC3, 1'b0};
        vecs[6] = '{3, 8'h0F, 8'hF0, 8'h0F, 8'hF0, 1'b0};
        vecs[7] = '{2, 8'h80, 8'h01, 8'h80, 8'h01, 1'b1};
        vecs[8] = '{4, 8'h96, 8'h2D, 8'h96, 8'h2D, 1'b0};

        rst  = 1'b0;
        mosi = 1'b0;
        for (int i = 0; i < N; i++) begin
            sck[i] = cpol_of(i); ss[i] = 1'b1;
            tx_data[i] = 8'h00; tx_valid[i] = 1'b0; rx_ready[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("rst_miso",     32'(miso[0]),       32'd0);
        check("rst_miso_oe",  32'(miso_oe[0]),    32'd0);
        check("rst_tx_ready", 32'(tx_ready[0]),   32'd0);
        check("rst_rx_data",  32'(rx_data[0]),    32'd0);
        check("rst_rx_valid", 32'(rx_valid[0]),   32'd0);
        check("rst_busy",     32'(busy[0]),       32'd0);
        check("rst_pulses",   {29'd0, rx_overrun[0], tx_underrun[0], frame_err[0]}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("tx_ready_after_rst", 32'(tx_ready[0]), 32'd1);
        repeat (4) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            d  = vecs[i].dut;
            u0 = und_cnt[d];
            push(d, vecs[i].tx);
            ss_low(d);
            check($sformatf("vec%0d_busy", i), 32'(busy[d]), 32'd1);
            push(d, 8'h00);
            xfer(d, vecs[i].mosi_w, 8, mw, fb);
            ss_high(d);
            check($sformatf("vec%0d_miso_word", i), 32'(mw), 32'(vecs[i].exp_miso));
            check($sformatf("vec%0d_first_bit", i), 32'(fb), 32'(vecs[i].exp_first));
            check($sformatf("vec%0d_rx_valid", i), 32'(rx_valid[d]), 32'd1);
            check($sformatf("vec%0d_rx_data", i), 32'(rx_data[d]), 32'(vecs[i].exp_rx));
            check($sformatf("vec%0d_underruns", i), 32'(und_cnt[d] - u0), 32'd0);
            pop(d);
        end

        // Back-to-back words, second one unfed, consumer stalled throughout.
        u0 = und_cnt[0]; o0 = ovr_cnt[0];
        push(0, 8'h12);
        ss_low(0);
        xfer(0, 8'h11, 8, mw, fb);
        push(0, 8'h34);
        xfer(0, 8'h22, 8, mw2, fb);
        ss_high(0);
        check("b2b_miso_word1", 32'(mw),  32'h12);
        check("b2b_miso_word2", 32'(mw2), 32'hFF);
        check("b2b_underruns",  32'(und_cnt[0] - u0), 32'd1);
        check("b2b_overruns",   32'(ovr_cnt[0] - o0), 32'd1);
        check("b2b_rx_data",    32'(rx_data[0]),  32'h11);
        check("b2b_rx_valid",   32'(rx_valid[0]), 32'd1);
        pop(0);

        // SS raised after 5 bits; holding word written mid-frame must survive.
        f0 = ferr_cnt[0];
        ss_low(0);
        push(0, 8'h99);
        xfer(0, 8'hA0, 5, mw, fb);
        ss_high(0);
        check("partial_frame_err", 32'(ferr_cnt[0] - f0), 32'd1);
        check("partial_rx_valid",  32'(rx_valid[0]), 32'd0);
        ss_low(0);
        push(0, 8'h00);
        xfer(0, 8'h7E, 8, mw, fb);
        ss_high(0);
        check("after_partial_miso",  32'(mw), 32'h99);
        check("after_partial_rx",    32'(rx_data[0]), 32'h7E);
        check("after_partial_valid", 32'(rx_valid[0]), 32'd1);
        check("after_partial_ferr",  32'(ferr_cnt[0] - f0), 32'd1);
        pop(0);

        // Reset after 3 bits with SS still low, then a fresh frame.
        f0 = ferr_cnt[0];
        ss_low(0);
        xfer(0, 8'h55, 3, mw, fb);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_busy",     32'(busy[0]),     32'd0);
        check("midrst_miso",     32'(miso[0]),     32'd0);
        check("midrst_miso_oe",  32'(miso_oe[0]),  32'd0);
        check("midrst_tx_ready", 32'(tx_ready[0]), 32'd0);
        check("midrst_rx_data",  32'(rx_data[0]),  32'd0);
        check("midrst_rx_valid", 32'(rx_valid[0]), 32'd0);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("postrst_no_restart", 32'(busy[0]),     32'd0);
        check("postrst_tx_ready",   32'(tx_ready[0]), 32'd1);
        check("postrst_no_ferr",    32'(ferr_cnt[0] - f0), 32'd0);
        ss[0] = 1'b1;
        repeat (8) @(negedge clk);
        push(0, 8'hB4);
        ss_low(0);
        push(0, 8'h00);
        xfer(0, 8'hC3, 8, mw, fb);
        ss_high(0);
        check("postrst_miso",     32'(mw), 32'hB4);
        check("postrst_rx_data",  32'(rx_data[0]), 32'hC3);
        check("postrst_rx_valid", 32'(rx_valid[0]), 32'd1);
        check("postrst_ferr",     32'(ferr_cnt[0] - f0), 32'd0);
        pop(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
